unsigned_mul_8x8_ha_array_accumulate: RTL and testbench
=======================================================

UNSIGNED_MUL_8X8_HA_ARRAY_ACCUMULATE -- requirements
Module: unsigned_mul_8x8_ha_array_accumulate

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter: OUT_W, 16, width of the product output; the only legal value is 16.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  the ha_array row set is valid.
REQ-006 Port: in_ready  output  1  the block can accept a row set.
REQ-007 Port: ha_array_0_b  input  7  bottom vector of row 0; ha_array_1_b, ha_array_2_b and ha_array_3_b are identical ports for rows 1-3.
REQ-008 Port: ha_array_0_t  input  9  top vector of row 0; ha_array_1_t, ha_array_2_t and ha_array_3_t are identical ports for rows 1-3.
REQ-009 Port: out_valid  output  1  the product is valid.
REQ-010 Port: out_ready  input  1  the downstream accepts the product.
REQ-011 Port: product  output  OUT_W  accumulated product.
REQ-012 Port: busy  output  1  high in the ACC and DONE states.

Function
REQ-013 Row value r_k SHALL be the sum over i=0..8 of t[i]*2^i plus the sum over i=0..6 of b[i]*2^(i+2); the maximum r_k is 1019.
REQ-014 The product SHALL be the sum over k=0..3 of r_k*2^(2k), truncated modulo 2^16 (the result wraps and no overflow flag is raised).
REQ-015 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, on in_valid&in_ready, the block SHALL register all eight input vectors, clear acc to 0, clear the 2-bit row counter cnt to 0, and go to ACC.
REQ-018 In IDLE with in_valid low, the block SHALL hold all state.
REQ-019 In ACC, on each edge, acc SHALL become acc + (r_cnt << 2*cnt) and cnt SHALL increment; exactly one row is added per cycle.
REQ-020 After the cnt==3 addition, the FSM SHALL go to DONE.
REQ-021 Inputs SHALL be sampled only at the accept edge; input changes during ACC or DONE SHALL have no effect.
REQ-022 In DONE, out_valid SHALL be 1 and product SHALL equal acc, held stable until out_ready.
REQ-023 In DONE with out_ready=1, the FSM SHALL return to IDLE at that edge; out_valid SHALL be low in the next cycle.
REQ-024 Latency: if accept occurs at edge E0, out_valid SHALL rise after edge E4, and the earliest next accept is at E6 (one result per 6 cycles minimum).
REQ-025 out_ready asserted outside DONE SHALL be ignored.
REQ-026 The accumulator SHALL be 16 bits and partial sums SHALL wrap modulo 2^16.

Reset
REQ-027 While rst=1, state SHALL be IDLE, acc=0, cnt=0, all captured vectors=0, out_valid=0, in_ready=1, product=0, busy=0, regardless of clk.
REQ-028 Reset asserted mid-ACC or in DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-029 After rst deasserts, the first accept SHALL be possible on the first clock edge.

Verification
REQ-030 All eight vectors zero, accept, out_ready=1 -> out_valid rises 4 edges after accept, product=0x0000.
REQ-031 Only ha_array_0_t=9'h001 -> product=1; only ha_array_3_b=7'h40 -> product=16384 (0x4000); only ha_array_1_b=7'h01 -> product=16 (0x0010).
REQ-032 All 64 input bits set -> r_k=1019, sum=86615, product=21079 (0x5257), demonstrating wrap.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and product stay stable and in_ready stays 0; product is accepted on the first out_ready=1 edge.
REQ-034 Reset at the second ACC cycle -> outputs return immediately to the REQ-027 values; a subsequent accept of zeros yields product=0 with no stale out_valid.
REQ-035 Random sweep over the 8x8 operand pairs: drive the rows from the unsigned_mul_8x8 ha_array generator -> product matches the REQ-014 reference model; input changes during ACC cause no mismatch.

Source files
------------

// File: rtl/unsigned_mul_8x8_ha_array_accumulate.sv
// ---------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_accumulate
//
// Accumulates four half-adder-array rows into a 16-bit product, one row per
// clock. Row k has a 9-bit top vector t and a 7-bit bottom vector b. Its value
// is r_k = t + 4*b, and it is weighted by 4^k. The sum wraps modulo 2^16.
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous active-high reset
//   in_valid / in_ready    input handshake for one set of four rows
//   ha_array_k_t [8:0]     top vector of row k (k = 0..3)
//   ha_array_k_b [6:0]     bottom vector of row k (k = 0..3)
//   out_valid / out_ready  output handshake for the product
//   product [OUT_W-1:0]    accumulated product
//   busy                   high while accumulating or holding a result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, so only one row set is in flight
// at a time. out_valid stays high and product stays stable until out_ready is
// sampled high. out_ready is ignored while out_valid is low.
//
// Timing: a row set is accepted at edge E0. Rows 0..3 are added at E1..E4.
// out_valid is high from E4 until the edge where out_ready is seen. The
// earliest next accept is E6.
// ---------------------------------------------------------------------------
module unsigned_mul_8x8_ha_array_accumulate #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0][8:0]  t_q;
    logic [3:0][6:0]  b_q;
    logic [15:0]      acc_q;
    logic [1:0]       cnt_q;

    logic [15:0]      row_val_d;
    logic [15:0]      addend_d;
    logic [15:0]      acc_d;

    // Value of the row selected by cnt_q. The maximum is 511 + 4*127 = 1019.
    // The value is shifted into place by 2*cnt_q. Bits above 15 drop off,
    // which gives the wrap modulo 2^16.
    always_comb begin
        row_val_d = {7'd0, t_q[cnt_q]} + {7'd0, b_q[cnt_q], 2'b00};
        addend_d  = row_val_d << {cnt_q, 1'b0};
        acc_d     = acc_q + addend_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        t_q     <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
                        b_q     <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    // cnt_q wraps from 3 back to 0, so it is already
                    // cleared for the next row set.
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The outputs are decoded directly from registered state. They settle to
    // their reset values as soon as rst rises.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACC) || (state_q == DONE);
    assign product   = acc_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accumulate.sv
module tb_unsigned_mul_8x8_ha_array_accumulate;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid;
  logic            in_ready;
  logic [3:0][8:0] t_v;
  logic [3:0][6:0] b_v;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     product;
  logic            busy;

  int vectors_applied = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  unsigned_mul_8x8_ha_array_accumulate #(.OUT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b_v[0]),
    .ha_array_1_b (b_v[1]),
    .ha_array_2_b (b_v[2]),
    .ha_array_3_b (b_v[3]),
    .ha_array_0_t (t_v[0]),
    .ha_array_1_t (t_v[1]),
    .ha_array_2_t (t_v[2]),
    .ha_array_3_t (t_v[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_product(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 4; k++) begin
      s = s + ((32'(t[k]) + 32'(b[k]) * 32'd4) << (2 * k));
    end
    return s[15:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_rows();
    t_v = '0;
    b_v = '0;
  endtask

  task automatic scramble_rows();
    for (int k = 0; k < 4; k++) begin
      t_v[k] = 9'($urandom_range(0, 511));
      b_v[k] = 7'($urandom_range(0, 127));
    end
  endtask

  // Row k covers multiplier bits 2k and 2k+1:
  //   r_k = a*y[2k] + 2*a*y[2k+1]
  // a*y[2k] and the 2*a[0] term go in t. a[7:1] goes in b, which carries
  // weight 4.
  task automatic gen_rows(input logic [7:0] a, input logic [7:0] y);
    for (int k = 0; k < 4; k++) begin
      t_v[k] = (y[2*k] ? {1'b0, a} : 9'd0) + (y[2*k+1] ? {7'd0, a[0], 1'b0} : 9'd0);
      b_v[k] = y[2*k+1] ? a[7:1] : 7'd0;
    end
  endtask

  // Accept the current rows, wait for the result, optionally stall, then drain.
  task automatic run_txn(input int stall, input bit early_ready);
    logic [15:0] exp;
    int n;
    check("in_ready_idle", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_rows();
    if (early_ready) out_ready = 1'b1;
    check("busy_acc", 16'(busy), 16'd1);
    check("in_ready_acc", 16'(in_ready), 16'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 16'(n), 16'd4);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("product", product, exp);
    if (!early_ready) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_valid", 16'(out_valid), 16'd1);
        check("stall_product", product, exp);
        check("stall_in_ready", 16'(in_ready), 16'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drained_valid", 16'(out_valid), 16'd0);
    check("drained_in_ready", 16'(in_ready), 16'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] op_a;
  logic [7:0] op_y;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_rows();
    #2;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_product", product, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // The first accept happens on the first edge after reset is released.
    clear_rows();
    exp_q.push_back(16'h0000);
    run_txn(0, 1'b0);

    clear_rows(); t_v[0] = 9'h001;
    exp_q.push_back(16'h0001);
    run_txn(0, 1'b0);

    clear_rows(); b_v[3] = 7'h40;
    exp_q.push_back(16'h4000);
    run_txn(0, 1'b1);

    clear_rows(); b_v[1] = 7'h01;
    exp_q.push_back(16'h0010);
    run_txn(0, 1'b0);

    clear_rows(); t_v[2] = 9'h1ff;              // 511 * 16 = 8176
    exp_q.push_back(16'h1ff0);
    run_txn(0, 1'b0);

    // All 64 bits set: 1019 * 85 = 86615, which wraps to 21079.
    t_v = '1; b_v = '1;
    exp_q.push_back(16'h5257);
    run_txn(10, 1'b0);

    // Reset during the second cycle in ACC.
    t_v = '1; b_v = '1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_product", product, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 16'(out_valid), 16'd0);
    end
    clear_rows();
    exp_q.push_back(16'h0000);
    run_txn(0, 1'b0);

    // Operand sweep using the multiplier row generator.
    for (int v = 0; v < 18; v++) begin
      case (v)
        0: begin op_a = 8'hff; op_y = 8'hff; end
        1: begin op_a = 8'h00; op_y = 8'hff; end
        2: begin op_a = 8'hff; op_y = 8'h01; end
        3: begin op_a = 8'h80; op_y = 8'h80; end
        default: begin
          op_a = 8'($urandom_range(0, 255));
          op_y = 8'($urandom_range(0, 255));
        end
      endcase
      gen_rows(op_a, op_y);
      exp_q.push_back(ref_product(t_v, b_v));
      run_txn(v % 3, (v % 4) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
